// File: rtl/flash_id_checker.sv
// Power-on SPI flash identification tester: after a power-up delay it reads the JEDEC ID
// over a built-in mode-0 SPI engine, compares it under mask, and retries a bounded number of times.
module flash_id_checker #(
  parameter int                    DELAY_BITS  = 16,
  parameter int                    ID_BYTES    = 3,
  parameter logic [8*ID_BYTES-1:0] EXPECTED_ID = 24'hEF4018,
  parameter logic [8*ID_BYTES-1:0] ID_MASK     = 24'hFF0000,
  parameter int                    CLK_DIV     = 1,
  parameter int                    MAX_RETRIES = 2,
  parameter int                    RETRY_GAP   = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    spi_clk,
  output logic                    spi_di,
  input  logic                    spi_do,
  output logic                    spi_cs,
  output logic                    test_in_progress,
  output logic                    test_result,
  output logic [8*ID_BYTES-1:0]   id_read,
  output logic [2:0]              retries_used
);

  // state     | meaning
  // INIT      | power-up delay, bus idle
  // CS_SETUP  | spi_cs low, command loaded
  // SHIFT_CMD | clocking out 0x9F
  // SHIFT_ID  | clocking in ID bytes
  // CS_HOLD   | spi_clk low, spi_cs still low
  // COMPARE   | judge the ID, decide retry
  // GAP       | spi_cs high between attempts
  // DONE      | result valid, waiting for start
  typedef enum logic [2:0] {
    INIT, CS_SETUP, SHIFT_CMD, SHIFT_ID, CS_HOLD, COMPARE, GAP, DONE
  } state_t;

  localparam int ID_W     = 8 * ID_BYTES;
  localparam int PH_W     = $clog2(2 * CLK_DIV);
  localparam int BIT_W    = $clog2(ID_W);
  // COMPARE already has spi_cs high, so GAP is one cycle shorter than the total gap.
  localparam int GAP_CYC  = (RETRY_GAP >= 2) ? RETRY_GAP - 1 : 1;
  localparam int WAIT_MAX = (GAP_CYC > CLK_DIV) ? GAP_CYC : CLK_DIV;
  localparam int WAIT_W   = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  localparam logic [PH_W-1:0]   PH_RISE  = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0]   PH_HIGH  = PH_W'(CLK_DIV);
  localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(2 * CLK_DIV - 1);
  localparam logic [BIT_W-1:0]  CMD_LAST = BIT_W'(7);
  localparam logic [BIT_W-1:0]  ID_LAST  = BIT_W'(ID_W - 1);
  localparam logic [WAIT_W-1:0] DIV_LOAD = WAIT_W'(CLK_DIV - 1);
  localparam logic [WAIT_W-1:0] GAP_LOAD = WAIT_W'(GAP_CYC - 1);
  localparam logic [2:0]        RETRY_MAX = 3'(MAX_RETRIES);

  state_t                state, state_nxt;
  logic [DELAY_BITS-1:0] delay_cnt;
  logic [WAIT_W-1:0]     wait_cnt;
  logic [PH_W-1:0]       phase_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [7:0]            cmd_sr;
  logic                  shifting, bit_end, rise, wait_done, id_pass, entering;

  assign shifting  = (state == SHIFT_CMD) || (state == SHIFT_ID);
  assign bit_end   = shifting && (phase_cnt == PH_LAST);
  assign rise      = shifting && (phase_cnt == PH_RISE);
  assign wait_done = (wait_cnt == '0);
  assign entering  = (state_nxt != state);
  // An all-zeros or all-ones ID means a floating or dead bus, whatever the mask says.
  assign id_pass   = ((id_read & ID_MASK) == (EXPECTED_ID & ID_MASK)) &&
                     (id_read != '0) && (id_read != '1);

  always_ff @(posedge clk) begin
    if (rst) state <= INIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      INIT:      if (delay_cnt == '1) state_nxt = CS_SETUP;
      CS_SETUP:  if (wait_done) state_nxt = SHIFT_CMD;
      SHIFT_CMD: if (bit_end && (bit_cnt == CMD_LAST)) state_nxt = SHIFT_ID;
      SHIFT_ID:  if (bit_end && (bit_cnt == ID_LAST)) state_nxt = CS_HOLD;
      CS_HOLD:   if (wait_done) state_nxt = COMPARE;
      COMPARE: begin
        if (id_pass)                         state_nxt = DONE;
        else if (retries_used < RETRY_MAX)   state_nxt = GAP;
        else                                 state_nxt = DONE;
      end
      GAP:       if (wait_done) state_nxt = CS_SETUP;
      DONE:      if (start) state_nxt = CS_SETUP;
      default:   state_nxt = INIT;
    endcase
  end

  always_comb begin
    spi_cs           = !((state == CS_SETUP) || shifting || (state == CS_HOLD));
    spi_clk          = shifting && (phase_cnt >= PH_HIGH);
    spi_di           = cmd_sr[7];
    test_in_progress = (state != DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      delay_cnt    <= '0;
      wait_cnt     <= '0;
      phase_cnt    <= '0;
      bit_cnt      <= '0;
      cmd_sr       <= 8'hFF;
      id_read      <= '0;
      test_result  <= 1'b0;
      retries_used <= 3'd0;
    end else begin
      if (state == INIT) delay_cnt <= delay_cnt + 1'b1;

      if (entering) begin
        case (state_nxt)
          CS_SETUP, CS_HOLD: wait_cnt <= DIV_LOAD;
          GAP:               wait_cnt <= GAP_LOAD;
          default:           wait_cnt <= '0;
        endcase
      end else if (!wait_done) begin
        wait_cnt <= wait_cnt - 1'b1;
      end

      if (entering) begin
        phase_cnt <= '0;
        bit_cnt   <= '0;
      end else if (shifting) begin
        if (phase_cnt == PH_LAST) begin
          phase_cnt <= '0;
          bit_cnt   <= bit_cnt + 1'b1;
        end else begin
          phase_cnt <= phase_cnt + 1'b1;
        end
      end

      // Shifting in ones leaves spi_di high for the whole ID phase.
      if (entering && (state_nxt == CS_SETUP))  cmd_sr <= 8'h9F;
      else if ((state == SHIFT_CMD) && bit_end) cmd_sr <= {cmd_sr[6:0], 1'b1};

      if (entering && (state_nxt == CS_SETUP))  id_read <= '0;
      else if ((state == SHIFT_ID) && rise)     id_read <= {id_read[ID_W-2:0], spi_do};

      if (state == COMPARE) begin
        if (id_pass)                       test_result  <= 1'b1;
        else if (retries_used < RETRY_MAX) retries_used <= retries_used + 1'b1;
        else                               test_result  <= 1'b0;
      end else if ((state == DONE) && start) begin
        test_result  <= 1'b0;
        retries_used <= 3'd0;
      end
    end
  end

endmodule

// File: tb/tb_flash_id_checker.sv
// Directed bench for flash_id_checker: a mode-0 flash model answering chosen IDs,
// plus a second instance with MISO tied high and an all-zero mask.
module tb_flash_id_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        spi_clk, spi_di, spi_cs;
  logic        spi_do = 1'b0;
  logic        tip, result;
  logic [23:0] id_read;
  logic [2:0]  retries;

  logic        rst_m0 = 1'b1;
  logic        m0_clk, m0_di, m0_cs, m0_tip, m0_result;
  logic [23:0] m0_id;
  logic [2:0]  m0_retries;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  flash_id_checker #(.DELAY_BITS(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .spi_clk(spi_clk), .spi_di(spi_di), .spi_do(spi_do), .spi_cs(spi_cs),
    .test_in_progress(tip), .test_result(result),
    .id_read(id_read), .retries_used(retries)
  );

  flash_id_checker #(.DELAY_BITS(4), .ID_MASK(24'h000000)) dut_m0 (
    .clk(clk), .rst(rst_m0), .start(1'b0),
    .spi_clk(m0_clk), .spi_di(m0_di), .spi_do(1'b1), .spi_cs(m0_cs),
    .test_in_progress(m0_tip), .test_result(m0_result),
    .id_read(m0_id), .retries_used(m0_retries)
  );

  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  // spi_cs window / gap monitor and mode-0 stability check, sampled mid-cycle
  logic stat_clr = 1'b0;
  int   windows = 0, hi_run = 0, gap_min = 0, gap_max = 0, mode0_viol = 0;
  logic prev_cs = 1'b1, prev_sclk = 1'b0, prev_di = 1'b1;

  always @(negedge clk) begin
    if (stat_clr) begin
      windows = 0; hi_run = 0; gap_min = 1000000; gap_max = 0; mode0_viol = 0;
    end
    if (spi_cs === 1'b0 && prev_cs === 1'b1) begin
      if (windows > 0) begin
        if (hi_run < gap_min) gap_min = hi_run;
        if (hi_run > gap_max) gap_max = hi_run;
      end
      windows++;
    end
    if (spi_cs === 1'b1) hi_run++;
    else hi_run = 0;
    if (spi_clk === 1'b1 && prev_sclk === 1'b0 && spi_di !== prev_di) mode0_viol++;
    prev_cs = spi_cs; prev_sclk = spi_clk; prev_di = spi_di;
  end

  // Flash model: samples MOSI on rising spi_clk, drives MISO after falling spi_clk
  int          bit_n = 0;
  logic [7:0]  mosi_sr = 8'h00, cmd_seen = 8'h00;
  logic [23:0] resp_first = 24'hEF4018, resp_rest = 24'hEF4018, cur;

  always @(negedge spi_cs) bit_n = 0;

  always @(posedge spi_clk) begin
    if (spi_cs === 1'b0) begin
      if (bit_n < 8) mosi_sr = {mosi_sr[6:0], spi_di};
      if (bit_n == 7) cmd_seen = mosi_sr;
      bit_n++;
    end
  end

  always @(negedge spi_clk) begin
    if (spi_cs === 1'b0 && bit_n >= 8 && bit_n < 32) begin
      cur = (windows <= 1) ? resp_first : resp_rest;
      spi_do = cur[31 - bit_n];
    end
  end

  int m0_windows = 0;
  always @(negedge m0_cs) m0_windows++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_done(input string tag, input int max_cyc, output int fall_cyc);
    int n = 0;
    while (tip !== 1'b0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(tip), 32'd0);
    fall_cyc = cyc;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_cs_low", 32'(spi_cs), 32'd0);
    check("start_tip", 32'(tip), 32'd1);
  endtask

  int fall;
  int n;

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    rst_m0 = 1'b0;
    check("rst_cs", 32'(spi_cs), 32'd1);
    check("rst_sclk", 32'(spi_clk), 32'd0);
    check("rst_di", 32'(spi_di), 32'd1);
    check("rst_tip", 32'(tip), 32'd1);
    check("rst_result", 32'(result), 32'd0);
    check("rst_id", 32'(id_read), 32'd0);
    check("rst_retries", 32'(retries), 32'd0);
    clear_stats();

    // T1: good flash, start pulsed during SHIFT_CMD must be ignored
    resp_first = 24'hEF4018; resp_rest = 24'hEF4018;
    rst = 1'b0;
    n = 0;
    while (cyc < 20 && n < 100) begin @(negedge clk); n++; end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t1_done", 2000, fall);
    check("t1_fall_cycle", 32'(fall), 32'd83);
    check("t1_mosi_cmd", 32'(cmd_seen), 32'h9F);
    check("t1_id", 32'(id_read), 32'hEF4018);
    check("t1_result", 32'(result), 32'd1);
    check("t1_retries", 32'(retries), 32'd0);
    check("t1_windows", 32'(windows), 32'd1);
    check("t1_mode0", 32'(mode0_viol), 32'd0);

    // T2: wrong manufacturer, all retries used
    resp_first = 24'hC22018; resp_rest = 24'hC22018;
    clear_stats();
    pulse_start();
    wait_done("t2_done", 3000, fall);
    check("t2_windows", 32'(windows), 32'd3);
    check("t2_gap_min", 32'(gap_min), 32'd256);
    check("t2_gap_max", 32'(gap_max), 32'd256);
    check("t2_id", 32'(id_read), 32'hC22018);
    check("t2_result", 32'(result), 32'd0);
    check("t2_retries", 32'(retries), 32'd2);
    check("t2_mode0", 32'(mode0_viol), 32'd0);

    // T3: dead bus first, good ID on the retry
    resp_first = 24'h000000; resp_rest = 24'hEF4018;
    clear_stats();
    pulse_start();
    wait_done("t3_done", 3000, fall);
    check("t3_windows", 32'(windows), 32'd2);
    check("t3_id", 32'(id_read), 32'hEF4018);
    check("t3_result", 32'(result), 32'd1);
    check("t3_retries", 32'(retries), 32'd1);

    // T4: reset in the middle of the ID phase
    resp_first = 24'hEF4018; resp_rest = 24'hEF4018;
    pulse_start();
    n = 0;
    while (bit_n < 12 && n < 200) begin @(negedge clk); n++; end
    check("t4_reached_id", 32'(bit_n >= 12), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("t4_rst_cs", 32'(spi_cs), 32'd1);
    check("t4_rst_sclk", 32'(spi_clk), 32'd0);
    check("t4_rst_id", 32'(id_read), 32'd0);
    check("t4_rst_tip", 32'(tip), 32'd1);
    rst = 1'b0;
    clear_stats();
    wait_done("t4_done", 2000, fall);
    check("t4_fall_cycle", 32'(fall), 32'd83);
    check("t4_result", 32'(result), 32'd1);
    check("t4_retries", 32'(retries), 32'd0);
    check("t4_windows", 32'(windows), 32'd1);

    // T5: MISO stuck high with zero mask on the second instance
    n = 0;
    while (m0_tip !== 1'b0 && n < 3000) begin @(negedge clk); n++; end
    check("m0_done", 32'(m0_tip), 32'd0);
    check("m0_id", 32'(m0_id), 32'hFFFFFF);
    check("m0_result", 32'(m0_result), 32'd0);
    check("m0_retries", 32'(m0_retries), 32'd2);
    check("m0_windows", 32'(m0_windows), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
